clk_div_bank: RTL and testbench

- Multi-channel, runtime-programmable clock-enable generator. It runs on the PLL output clock and derives per-channel sample/strobe rates for the scope datapath.
- Supersedes a fixed single-ratio output divider. Adds per-channel divide ratio, phase offset, glitch-free ratio updates, a global realign strobe, and per-channel lock status.
- Outputs are single-cycle clock enables plus registered ~50% duty "clock-like" levels for pins and debug. They are not used as fabric clocks.

---
 rtl/clk_div_bank.sv | 148 ++++++++++++++
 tb/tb_clk_div_bank.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable clock-enable generator.
// Every channel counts 0..D and emits a one-cycle enable plus a ~50% duty level.
// Ratio and phase updates are held pending and take effect only at the end of a
// period, or at once on sync, so a period is never cut short by a write.
//
// Ports:
//   clkin      sole clock (PLL output domain)
//   reset      synchronous, active-high reset
//   cfg_we     configuration write strobe (one cycle)
//   cfg_ch     target channel; values >= N_CH are ignored
//   cfg_div    new divide value D (period D+1)
//   cfg_phase  new phase offset, loaded into the counter on sync
//   sync       global realign pulse, all channels
//   ce_o       per-channel one-cycle enable, once per period
//   clk_o      per-channel registered square wave
//   lock_o     channel has run a committed config for a full period
module clk_div_bank #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned RESET_DIV = 3
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic              sync,
    output logic [N_CH-1:0]   ce_o,
    output logic [N_CH-1:0]   clk_o,
    output logic [N_CH-1:0]   lock_o
);

    // Per-channel state
    logic [DIV_W-1:0] act_div_q   [N_CH];
    logic [DIV_W-1:0] act_div_d   [N_CH];
    logic [DIV_W-1:0] act_phase_q [N_CH];
    logic [DIV_W-1:0] act_phase_d [N_CH];
    logic [DIV_W-1:0] pend_div_q  [N_CH];
    logic [DIV_W-1:0] pend_div_d  [N_CH];
    logic [DIV_W-1:0] pend_phase_q[N_CH];
    logic [DIV_W-1:0] pend_phase_d[N_CH];
    logic [DIV_W-1:0] cnt_q       [N_CH];
    logic [DIV_W-1:0] cnt_d       [N_CH];
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  ce_q, ce_d;
    logic [N_CH-1:0]  clk_q, clk_d;
    logic [N_CH-1:0]  lock_q, lock_d;

    // Combinational helpers
    logic             cfg_ok_c;
    logic [N_CH-1:0]  bnd_c;
    logic [N_CH-1:0]  wr_c;
    logic [N_CH-1:0]  commit_c;
    logic [DIV_W-1:0] src_div_c   [N_CH];
    logic [DIV_W-1:0] src_phase_c [N_CH];
    logic [DIV_W-1:0] new_div_c   [N_CH];
    logic [DIV_W-1:0] new_phase_c [N_CH];

    assign cfg_ok_c = 32'(cfg_ch) < 32'(N_CH);

    // Next-state logic for every channel
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            act_div_d[c]    = act_div_q[c];
            act_phase_d[c]  = act_phase_q[c];
            pend_div_d[c]   = pend_div_q[c];
            pend_phase_d[c] = pend_phase_q[c];
            pend_d[c]       = pend_q[c];

            bnd_c[c] = (cnt_q[c] == act_div_q[c]);
            wr_c[c]  = cfg_we && cfg_ok_c && (cfg_ch == 4'(c));

            // A same-cycle write bypasses the pend registers (last write wins)
            src_div_c[c]   = wr_c[c] ? cfg_div   : pend_div_q[c];
            src_phase_c[c] = wr_c[c] ? cfg_phase : pend_phase_q[c];
            commit_c[c]    = (wr_c[c] || pend_q[c]) && (sync || bnd_c[c]);

            new_div_c[c]   = commit_c[c] ? src_div_c[c]   : act_div_q[c];
            new_phase_c[c] = commit_c[c] ? src_phase_c[c] : act_phase_q[c];

            if (commit_c[c]) begin
                act_div_d[c]   = src_div_c[c];
                act_phase_d[c] = src_phase_c[c];
                pend_d[c]      = 1'b0;
            end else if (wr_c[c]) begin
                pend_div_d[c]   = cfg_div;
                pend_phase_d[c] = cfg_phase;
                pend_d[c]       = 1'b1;
            end

            // sync beats the boundary wrap; phase is clamped to the new divide
            if (sync) begin
                cnt_d[c] = (new_phase_c[c] > new_div_c[c]) ? new_div_c[c] : new_phase_c[c];
            end else if (bnd_c[c]) begin
                cnt_d[c] = '0;
            end else begin
                cnt_d[c] = cnt_q[c] + DIV_W'(1);
            end

            ce_d[c]  = bnd_c[c];
            clk_d[c] = (cnt_q[c] <= (act_div_q[c] >> 1));

            // Lock drops on write or commit, rises on the first enable after that
            if (wr_c[c] || commit_c[c]) begin
                lock_d[c] = 1'b0;
            end else if (bnd_c[c]) begin
                lock_d[c] = 1'b1;
            end else begin
                lock_d[c] = lock_q[c];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clkin) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                act_div_q[c]    <= DIV_W'(RESET_DIV);
                act_phase_q[c]  <= '0;
                pend_div_q[c]   <= '0;
                pend_phase_q[c] <= '0;
                cnt_q[c]        <= '0;
            end
            pend_q <= '0;
            ce_q   <= '0;
            clk_q  <= '0;
            lock_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                act_div_q[c]    <= act_div_d[c];
                act_phase_q[c]  <= act_phase_d[c];
                pend_div_q[c]   <= pend_div_d[c];
                pend_phase_q[c] <= pend_phase_d[c];
                cnt_q[c]        <= cnt_d[c];
            end
            pend_q <= pend_d;
            ce_q   <= ce_d;
            clk_q  <= clk_d;
            lock_q <= lock_d;
        end
    end

    assign ce_o   = ce_q;
    assign clk_o  = clk_q;
    assign lock_o = lock_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank: directed test-plan scenarios followed by random
// traffic, checked against a per-channel behavioural model through a queue.
module tb_clk_div_bank;

    localparam int unsigned N_CH      = 4;
    localparam int unsigned DIV_W     = 16;
    localparam int unsigned RESET_DIV = 3;

    logic              clkin = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [DIV_W-1:0]  cfg_phase = '0;
    logic              sync = 1'b0;
    logic [N_CH-1:0]   ce_o, clk_o, lock_o;

    clk_div_bank #(.N_CH(N_CH), .DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
        .clkin    (clkin),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
        .sync     (sync),
        .ce_o     (ce_o),
        .clk_o    (clk_o),
        .lock_o   (lock_o)
    );

    always #5 clkin = ~clkin;

    typedef struct packed {
        logic [N_CH-1:0] ce;
        logic [N_CH-1:0] clk;
        logic [N_CH-1:0] lock;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   drive_done = 0;

    // Reference model: where each channel sits within its period, plus its configs
    int m_div  [N_CH];
    int m_ph   [N_CH];
    int m_pdiv [N_CH];
    int m_pph  [N_CH];
    bit m_pend [N_CH];
    int m_pos  [N_CH];
    bit m_lock [N_CH];

    // Advance the model by one clock edge; returns outputs visible after that edge
    task automatic model_step(input bit r, input bit we, input int ch, input int dv,
                              input int ph, input bit sy, output exp_t e);
        e = '0;
        for (int c = 0; c < N_CH; c++) begin
            bit at_end, written, swapped;
            if (r) begin
                m_div[c] = RESET_DIV; m_ph[c] = 0; m_pend[c] = 0;
                m_pos[c] = 0; m_lock[c] = 0;
                continue;
            end
            at_end  = (m_pos[c] == m_div[c]);
            e.ce[c] = at_end;
            // high for the first half (rounded up) of the period
            e.clk[c] = (m_pos[c] <= m_div[c] / 2);
            written = we && (ch == c);
            if (written) begin
                m_pdiv[c] = dv; m_pph[c] = ph; m_pend[c] = 1;
            end
            swapped = m_pend[c] && (sy || at_end);
            if (swapped) begin
                m_div[c] = m_pdiv[c]; m_ph[c] = m_pph[c]; m_pend[c] = 0;
            end
            if (written || swapped) m_lock[c] = 0;
            else if (at_end)        m_lock[c] = 1;
            if (sy)          m_pos[c] = (m_ph[c] < m_div[c]) ? m_ph[c] : m_div[c];
            else if (at_end) m_pos[c] = 0;
            else             m_pos[c] = m_pos[c] + 1;
            e.lock[c] = m_lock[c];
        end
    endtask

    // Drive one cycle of inputs and queue the expected response
    task automatic cyc(input bit r, input bit we, input int ch, input int dv,
                       input int ph, input bit sy);
        exp_t e;
        @(negedge clkin);
        reset     = r;
        cfg_we    = we;
        cfg_ch    = 4'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_phase = DIV_W'(ph);
        sync      = sy;
        model_step(r, we, ch, dv, ph, sy, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %b, expected %b", nm, $time, act, exp);
    endtask

    // Monitor: outputs are presented every cycle; compare them against the queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clkin);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ce_o",   ce_o,   e.ce);
                chk("clk_o",  clk_o,  e.clk);
                chk("lock_o", lock_o, e.lock);
            end
        end
    end

    // Stimulus
    initial begin
        int guard;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(20);

        // ch1 -> /10 written mid-period
        guard = 0;
        while (m_pos[1] != 1 && guard < 50) begin idle(1); guard++; end
        cyc(0, 1, 1, 9, 0, 0);
        idle(30);

        // two writes to ch2 before its boundary: only the last one commits
        guard = 0;
        while (m_pos[2] != 0 && guard < 50) begin idle(1); guard++; end
        cyc(0, 1, 2, 5, 0, 0);
        cyc(0, 1, 2, 7, 0, 0);
        idle(30);

        // ch0 div=4 phase=2 together with sync
        cyc(0, 1, 0, 4, 2, 1);
        idle(20);

        // ch3 div=0, then ch2 div=4 phase=10 followed by sync (clamp)
        cyc(0, 1, 3, 0, 0, 0);
        idle(6);
        cyc(0, 1, 2, 4, 10, 0);
        cyc(0, 0, 0, 0, 0, 1);
        idle(15);

        // reset while ch1 has a pending write, then an out-of-range write
        cyc(0, 1, 1, 12, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(2);
        cyc(0, 1, 5, 7, 1, 0);
        idle(12);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, we, sy;
            int ch, dv, ph;
            r  = ($urandom_range(0, 499) == 0);
            we = ($urandom_range(0, 5) == 0);
            sy = ($urandom_range(0, 39) == 0);
            ch = $urandom_range(0, 7);
            if ($urandom_range(0, 49) == 0) begin
                dv = 16'hFFFF - $urandom_range(0, 2);
                ph = 16'hFFFF - $urandom_range(0, 8);
            end else begin
                dv = $urandom_range(0, 12);
                ph = $urandom_range(0, 15);
            end
            cyc(r, we, ch, dv, ph, sy);
        end
        idle(3);
        drive_done = 1;
    end

    // Finish once stimulus is done and every queued response has been compared
    initial begin
        wait (drive_done);
        @(negedge clkin);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
